pc_jump_unit: RTL and testbench
===============================

Name: pc_jump_unit

Overview:
- Program-counter block and consumer of the 26-bit J-type jump index that the instruction datapath forwards.
- Holds the 32-bit PC, presents fetch addresses to instruction memory over a valid/ready handshake, and forms jump and branch targets.
- Buffers one redirect that arrives while fetch is stalled.
- Sits between the decode/control path, which produces the jump index and branch offset, and the instruction memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  leave IDLE or HALT and begin fetching
pc_out  output  32  current fetch address
pc_valid  output  1  pc_out is a valid fetch request
pc_ready  input  1  instruction memory accepts pc_out this cycle
jump_req  input  1  jump redirect request
jump_index  input  26  J-type target field
branch_req  input  1  taken-branch redirect request
branch_offset  input  16  signed word offset
halt_req  input  1  stop fetching
redirect_ack  output  1  one-cycle pulse: redirect captured
halted  output  1  block is in HALT

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset, sampled only on the rising edge of clk.
- Reset, including mid-operation: pc_out=RESET_PC, pc_valid=0, redirect_ack=0, halted=0, pending cleared, state=IDLE. Reset overrides every other input in the same cycle.
- States: IDLE, RUN, HALT.
  - IDLE: pc_valid=0. start -> RUN. All other inputs are ignored.
  - RUN: pc_valid=1. halt_req -> HALT at the next edge. start is ignored.
  - HALT: pc_valid=0, halted=1. pc and pending are retained. start -> RUN. Redirect requests are ignored and redirect_ack stays 0.
- Handshake: a fetch completes on a cycle with pc_valid && pc_ready.
  - pc_out must hold stable while pc_valid=1 and pc_ready=0.
  - pc_out updates only on the edge that ends a completed fetch.
- Target arithmetic uses base = pc_out in the capture cycle, and pc_plus4 = base + 4 (modulo 2^32).
  - Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
  - Branch target = pc_plus4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}), modulo 2^32.
  - Priority: jump over branch when both are asserted.
- Redirect capture (RUN only): any jump_req or branch_req is captured. redirect_ack=1 in the following cycle, for exactly one cycle per captured request.
  - Capture without a completed fetch: the target is stored in the one-entry pending register. A newer capture overwrites an older pending entry.
  - Capture in a completed-fetch cycle: the new target loads the PC directly, and pending is cleared.
- Next PC on a completed fetch, in priority order:
  1. Same-cycle redirect target.
  2. Pending target; pending is then cleared.
  3. pc_out + 4. 0xFFFF_FFFC wraps to 0x0000_0000.
- Simultaneous events:
  - halt_req together with a completed fetch: the PC advances, then the block enters HALT.
  - halt_req together with a redirect: the redirect is captured into pending, then the block enters HALT.
- Latency: redirect to pc_out is 1 cycle when fetch completes in the capture cycle; otherwise it is the edge ending the next completed fetch.

Decomposition:
- Package cse331_pc_pkg holds:
  - State enum IDLE/RUN/HALT.
  - Width constants: PC_W=32, JIDX_W=26, BOFF_W=16.
  - Default RESET_PC.
- Sub-module pc_target_calc (combinational): inputs base, jump_req, jump_index, branch_offset; outputs target and hit. Unit-tested on its own.

Test Plan:
- Reset mid-RUN with pending valid: on the next edge pc_out=RESET_PC, pc_valid=0, state IDLE, pending is gone, and a later start fetches RESET_PC.
- start, pc_ready=1 for 3 cycles from 0x0: pc_out shows 0x0, 0x4, 0x8, 0xC. RESET_PC=0xFFFF_FFF8 gives 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- pc_out=0x4000_0010, jump_req with jump_index=0x0000123, pc_ready=1: next pc_out=0x4000_048C, redirect_ack pulses once.
- pc_out=0x100, branch_offset=0xFFFE, pc_ready=0: pc_out holds 0x100 while stalled. When pc_ready=1, next pc_out=0xFC.
- pc_ready=0, branch_req then jump_req (jump_index=0x40) on later cycles: pending holds the jump target. On release, pc_out=0x100, and redirect_ack has pulsed twice.
- halt_req with pc_ready=1 at pc_out=0x20: pc_out=0x24, pc_valid=0, halted=1. jump_req in HALT gives no ack. start resumes at 0x24.

Source files
------------

// File: rtl/pc_jump_unit_pkg.sv
// Shared types and constants for the program-counter / jump-target block.
package cse331_pc_pkg;

  localparam int PC_W   = 32;
  localparam int JIDX_W = 26;
  localparam int BOFF_W = 16;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target former: J-type region jump or PC-relative branch.
module pc_target_calc
  import cse331_pc_pkg::*;
(
  input  logic [PC_W-1:0]   base,
  input  logic              jump_req,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [BOFF_W-1:0] branch_offset,
  output logic [PC_W-1:0]   target,
  output logic              hit
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] boff_ext;

  assign pc_plus4 = base + 32'd4;
  // Word offset becomes a byte offset: sign-extend and shift left by two.
  assign boff_ext = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  // Jump wins over branch; hit flags that the jump form was chosen.
  always_comb begin
    target = pc_plus4 + boff_ext;
    hit    = 1'b0;
    if (jump_req) begin
      target = {pc_plus4[31:28], jump_index, 2'b00};
      hit    = 1'b1;
    end else begin
      target = pc_plus4 + boff_ext;
      hit    = 1'b0;
    end
  end

endmodule

// File: rtl/pc_jump_unit.sv
// Program counter with valid/ready fetch port and a one-entry redirect buffer.
module pc_jump_unit
  import cse331_pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic              jump_req,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_req,
  input  logic [BOFF_W-1:0] branch_offset,
  input  logic              halt_req,
  output logic              redirect_ack,
  output logic              halted
);

  state_t          state;
  state_t          state_next;
  logic            pend_valid;
  logic [PC_W-1:0] pend_target;
  logic [PC_W-1:0] target;
  logic            jump_hit;
  logic            fire;
  logic            redir;
  logic [PC_W-1:0] pc_next;

  pc_target_calc u_calc (
    .base          (pc_out),
    .jump_req      (jump_req),
    .jump_index    (jump_index),
    .branch_offset (branch_offset),
    .target        (target),
    .hit           (jump_hit)
  );

  assign fire  = (state == RUN) && pc_ready;
  assign redir = (state == RUN) && (jump_req || branch_req);

  // Next-state decode; halt takes effect after this cycle's fetch/capture.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;  else state_next = IDLE;
      RUN:     if (halt_req) state_next = HALT; else state_next = RUN;
      HALT:    if (start)    state_next = RUN;  else state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Fresh redirect beats the buffered one, which beats sequential fetch.
  always_comb begin
    pc_next = pc_out + 32'd4;
    if (redir) begin
      pc_next = target;
    end else if (pend_valid) begin
      pc_next = pend_target;
    end else begin
      pc_next = pc_out + 32'd4;
    end
  end

  // State, PC, pending buffer and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_out       <= RESET_PC;
      pend_valid   <= 1'b0;
      pend_target  <= RESET_PC;
      pc_valid     <= 1'b0;
      halted       <= 1'b0;
      redirect_ack <= 1'b0;
    end else begin
      state        <= state_next;
      pc_valid     <= (state_next == RUN);
      halted       <= (state_next == HALT);
      redirect_ack <= redir;
      if (fire) begin
        pc_out     <= pc_next;
        pend_valid <= 1'b0;
      end else if (redir) begin
        pend_valid  <= 1'b1;
        pend_target <= target;
      end
    end
  end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit (three reset vectors) and pc_target_calc.
module tb_pc_jump_unit;
  import cse331_pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, pc_ready, jump_req, branch_req, halt_req;
  logic [25:0] jump_index;
  logic [15:0] branch_offset;
  logic [31:0] pc_a, pc_b, pc_c;
  logic        valid_a, valid_b, valid_c, ack_a, ack_b, ack_c, halt_a, halt_b, halt_c;

  logic [31:0] tc_base, tc_target;
  logic        tc_jump, tc_hit;
  logic [25:0] tc_idx;
  logic [15:0] tc_off;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_jump_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pc_out(pc_a), .pc_valid(valid_a),
    .pc_ready(pc_ready), .jump_req(jump_req), .jump_index(jump_index),
    .branch_req(branch_req), .branch_offset(branch_offset), .halt_req(halt_req),
    .redirect_ack(ack_a), .halted(halt_a));

  pc_jump_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pc_out(pc_b), .pc_valid(valid_b),
    .pc_ready(pc_ready), .jump_req(jump_req), .jump_index(jump_index),
    .branch_req(branch_req), .branch_offset(branch_offset), .halt_req(halt_req),
    .redirect_ack(ack_b), .halted(halt_b));

  pc_jump_unit #(.RESET_PC(32'h4000_0010)) dut_c (
    .clk(clk), .reset(reset), .start(start), .pc_out(pc_c), .pc_valid(valid_c),
    .pc_ready(pc_ready), .jump_req(jump_req), .jump_index(jump_index),
    .branch_req(branch_req), .branch_offset(branch_offset), .halt_req(halt_req),
    .redirect_ack(ack_c), .halted(halt_c));

  pc_target_calc u_tc (
    .base(tc_base), .jump_req(tc_jump), .jump_index(tc_idx),
    .branch_offset(tc_off), .target(tc_target), .hit(tc_hit));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc_ready = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
    halt_req = 1'b0; jump_index = 26'd0; branch_offset = 16'd0;

    // Target former on its own
    tc_base = 32'h4000_0010; tc_jump = 1'b1; tc_idx = 26'h0000123; tc_off = 16'h0000;
    #1;
    chk("tc_jump", tc_target, 32'h4000_048C);
    chk("tc_hit1", {31'd0, tc_hit}, 32'd1);
    tc_base = 32'h0000_0100; tc_jump = 1'b0; tc_off = 16'hFFFE;
    #1;
    chk("tc_branch_neg", tc_target, 32'h0000_00FC);
    chk("tc_hit0", {31'd0, tc_hit}, 32'd0);
    tc_base = 32'hFFFF_FFFC; tc_off = 16'h0001;
    #1;
    chk("tc_branch_wrap", tc_target, 32'h0000_0004);
    tc_base = 32'hF000_0000; tc_jump = 1'b1; tc_idx = 26'h3FF_FFFF;
    #1;
    chk("tc_jump_region", tc_target, 32'hFFFF_FFFC);

    // Reset state
    tick();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_halted", {31'd0, halt_a}, 32'd0);
    chk("rst_ack", {31'd0, ack_a}, 32'd0);
    chk("rst_pc_b", pc_b, 32'hFFFF_FFF8);

    // Start and sequential fetch
    reset = 1'b0; start = 1'b1; pc_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", {31'd0, valid_a}, 32'd1);
    chk("seq0", pc_a, 32'h0);
    tick();
    chk("seq1", pc_a, 32'h4);
    chk("seq1_b", pc_b, 32'hFFFF_FFFC);
    tick();
    chk("seq2", pc_a, 32'h8);
    chk("seq2_b", pc_b, 32'h0000_0000);
    tick();
    chk("seq3", pc_a, 32'hC);

    // Jump with completed fetch: 0xC -> 0x100
    jump_req = 1'b1; jump_index = 26'h40;
    tick();
    chk("jmp_fire_pc", pc_a, 32'h100);
    chk("jmp_fire_ack", {31'd0, ack_a}, 32'd1);

    // Stalled branch -1 word... offset 0xFFFE from 0x100 buffers 0xFC
    jump_req = 1'b0; branch_req = 1'b1; branch_offset = 16'hFFFE; pc_ready = 1'b0;
    tick();
    chk("br_stall_pc", pc_a, 32'h100);
    chk("br_stall_ack", {31'd0, ack_a}, 32'd1);
    branch_req = 1'b0;
    tick();
    chk("br_hold_pc", pc_a, 32'h100);
    chk("br_ack_once", {31'd0, ack_a}, 32'd0);
    pc_ready = 1'b1;
    tick();
    chk("br_release_pc", pc_a, 32'hFC);
    pc_ready = 1'b0;

    // Newer capture overwrites pending: branch then jump while stalled at 0xFC
    branch_req = 1'b1; branch_offset = 16'h0010;
    tick();
    chk("ow_ack1", {31'd0, ack_a}, 32'd1);
    branch_req = 1'b0; jump_req = 1'b1; jump_index = 26'h40;
    tick();
    chk("ow_ack2", {31'd0, ack_a}, 32'd1);
    chk("ow_hold_pc", pc_a, 32'hFC);
    jump_req = 1'b0;
    tick();
    chk("ow_ack_end", {31'd0, ack_a}, 32'd0);
    pc_ready = 1'b1;
    tick();
    chk("ow_release_pc", pc_a, 32'h100);
    tick();
    chk("ow_pend_cleared", pc_a, 32'h104);

    // Halt with completed fetch at 0x20
    jump_req = 1'b1; jump_index = 26'h8;
    tick();
    chk("to_0x20", pc_a, 32'h20);
    jump_req = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_pc", pc_a, 32'h24);
    chk("halt_valid", {31'd0, valid_a}, 32'd0);
    chk("halt_flag", {31'd0, halt_a}, 32'd1);
    jump_req = 1'b1; jump_index = 26'h100;
    tick();
    jump_req = 1'b0;
    chk("halt_no_ack", {31'd0, ack_a}, 32'd0);
    chk("halt_pc_kept", pc_a, 32'h24);
    pc_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_valid", {31'd0, valid_a}, 32'd1);
    chk("resume_halted", {31'd0, halt_a}, 32'd0);
    chk("resume_pc", pc_a, 32'h24);

    // Halt together with a stalled redirect: buffered, then used after resume
    halt_req = 1'b1; branch_req = 1'b1; branch_offset = 16'h0001;
    tick();
    halt_req = 1'b0; branch_req = 1'b0;
    chk("hr_halted", {31'd0, halt_a}, 32'd1);
    chk("hr_ack", {31'd0, ack_a}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0; pc_ready = 1'b1;
    tick();
    chk("hr_pend_pc", pc_a, 32'h2C);

    // Reset mid-RUN with pending valid
    pc_ready = 1'b0; branch_req = 1'b1; branch_offset = 16'h0004;
    tick();
    branch_req = 1'b0; reset = 1'b1; jump_req = 1'b1; start = 1'b1;
    tick();
    chk("mid_rst_pc", pc_a, 32'h0);
    chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    chk("mid_rst_ack", {31'd0, ack_a}, 32'd0);
    reset = 1'b0; jump_req = 1'b0; pc_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_rst_restart", pc_a, 32'h0);
    tick();
    chk("mid_rst_no_pend", pc_a, 32'h4);

    // Jump in the high region, checked on the 0x4000_0010 instance
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1; pc_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("c_start_pc", pc_c, 32'h4000_0010);
    jump_req = 1'b1; jump_index = 26'h0000123; pc_ready = 1'b1;
    tick();
    jump_req = 1'b0; pc_ready = 1'b0;
    chk("c_jump_pc", pc_c, 32'h4000_048C);
    chk("c_jump_ack", {31'd0, ack_c}, 32'd1);
    tick();
    chk("c_ack_once", {31'd0, ack_c}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
